// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory between fetch and data ports, data first with fetch anti-starvation
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int READ_LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              gnt_if,
  output logic              gnt_dm,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic we_q, we_d, pick_if;
  logic gnt_if_q, gnt_if_d, gnt_dm_q, gnt_dm_d;
  logic mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  assign pick_if = if_req && (!dm_req || starve_cnt_q == SW'(STARVE_MAX));
  always_comb begin
    state_d = state_q;
    wait_cnt_d = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    we_d = we_q;
    gnt_if_d = gnt_if_q;
    gnt_dm_d = gnt_dm_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    mem_re_d = 1'b0;
    mem_we_d = 1'b0;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    case (state_q)
      IDLE: if (if_req || dm_req) begin
        gnt_if_d = pick_if;
        gnt_dm_d = !pick_if;
        we_d = !pick_if && dm_we;
        mem_addr_d = pick_if ? if_addr : dm_addr;
        mem_wdata_d = dm_wdata;
        mem_re_d = !we_d;
        mem_we_d = we_d;
        starve_cnt_d = pick_if ? '0 : (if_req && starve_cnt_q != SW'(STARVE_MAX)) ? starve_cnt_q + 1'b1 : starve_cnt_q;
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = we_q ? RESP : WAIT;
        wait_cnt_d = 3'(READ_LAT);
        dm_valid_d = we_q;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 1'b1;
        if (wait_cnt_q == 3'd1) begin
          state_d = RESP;
          if_rdata_d = gnt_if_q ? mem_rdata : if_rdata_q;
          dm_rdata_d = gnt_dm_q ? mem_rdata : dm_rdata_q;
          if_valid_d = gnt_if_q;
          dm_valid_d = gnt_dm_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_cnt_q <= '0;
      starve_cnt_q <= '0;
      we_q <= 1'b0;
      gnt_if_q <= 1'b0;
      gnt_dm_q <= 1'b0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      we_q <= we_d;
      gnt_if_q <= gnt_if_d;
      gnt_dm_q <= gnt_dm_d;
      mem_re_q <= mem_re_d;
      mem_we_q <= mem_we_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end
  assign if_rdata = if_rdata_q;
  assign if_valid = if_valid_q;
  assign dm_rdata = dm_rdata_q;
  assign dm_valid = dm_valid_q;
  assign gnt_if = gnt_if_q;
  assign gnt_dm = gnt_dm_q;
  assign mem_re = mem_re_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter at READ_LAT=1 and a reset-mid-read case at READ_LAT=3
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1, rst3 = 1;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata = 0;
  logic if_valid, dm_valid, gnt_if, gnt_dm, mem_re, mem_we;
  logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3, mem_rdata3 = 0;
  logic if_valid3, dm_valid3, gnt_if3, gnt_dm3, mem_re3, mem_we3;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.READ_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_valid(dm_valid), .gnt_if(gnt_if), .gnt_dm(gnt_dm), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
  mem_port_arbiter #(.READ_LAT(3), .STARVE_MAX(4)) u3 (
    .clk(clk), .rst(rst3), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata3), .if_valid(if_valid3),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata3),
    .dm_valid(dm_valid3), .gnt_if(gnt_if3), .gnt_dm(gnt_dm3), .mem_re(mem_re3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3));
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h4) ? 32'h00500293 : (a ^ 32'hA5A50000);
  endfunction
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= memf(mem_addr);
    if (mem_re3) mem_rdata3 <= memf(mem_addr3);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    if_req = 1; dm_req = 1; if_addr = 32'h4; dm_addr = 32'h80;
    tick();
    chk("rst_outs_c1", {30'd0, mem_re, mem_we} | {30'd0, if_valid, dm_valid} | {30'd0, gnt_if, gnt_dm}, 0);
    chk("rst_addr_c1", mem_addr, 0);
    tick();
    chk("rst_outs_c2", {30'd0, mem_re, mem_we} | {30'd0, if_valid, dm_valid} | {30'd0, gnt_if, gnt_dm}, 0);
    rst = 0;
    chk("rst_re_t0", {31'd0, mem_re}, 0);
    tick();
    chk("rst_re_t1", {31'd0, mem_re}, 1);
    chk("rst_gnt_dm", {31'd0, gnt_dm}, 1);
    chk("rst_addr_t1", mem_addr, 32'h80);
    dm_req = 0; if_req = 0;
    tick();
    tick();
    chk("rst_dm_valid", {31'd0, dm_valid}, 1);
    chk("rst_dm_rdata", dm_rdata, 32'hA5A50080);
    tick();
    // fetch
    if_req = 1; if_addr = 32'h4;
    tick();
    chk("f_re", {31'd0, mem_re}, 1);
    chk("f_addr", mem_addr, 32'h4);
    chk("f_gnt_if", {31'd0, gnt_if}, 1);
    tick();
    chk("f_valid_t2", {31'd0, if_valid}, 0);
    tick();
    chk("f_valid_t3", {31'd0, if_valid}, 1);
    chk("f_rdata", if_rdata, 32'h00500293);
    chk("f_dm_valid", {31'd0, dm_valid}, 0);
    if_req = 0;
    tick();
    chk("f_valid_t4", {31'd0, if_valid}, 0);
    // store
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h64;
    tick();
    chk("s_we", {31'd0, mem_we}, 1);
    chk("s_re", {31'd0, mem_re}, 0);
    chk("s_addr", mem_addr, 32'h40);
    chk("s_wdata", mem_wdata, 32'h64);
    tick();
    chk("s_valid", {31'd0, dm_valid}, 1);
    chk("s_we_t2", {31'd0, mem_we}, 0);
    chk("s_re_t2", {31'd0, mem_re}, 0);
    dm_req = 0; dm_we = 0;
    tick();
    chk("s_valid_t3", {31'd0, dm_valid}, 0);
    // collision
    if_req = 1; if_addr = 32'h4; dm_req = 1; dm_addr = 32'h80;
    tick();
    chk("c_t1_re", {31'd0, mem_re}, 1);
    chk("c_t1_addr", mem_addr, 32'h80);
    chk("c_t1_gnt", {30'd0, gnt_if, gnt_dm}, 1);
    tick();
    tick();
    chk("c_t3_dm_valid", {31'd0, dm_valid}, 1);
    chk("c_t3_dm_rdata", dm_rdata, 32'hA5A50080);
    dm_req = 0;
    tick();
    chk("c_t4_re", {31'd0, mem_re}, 0);
    tick();
    chk("c_t5_re", {31'd0, mem_re}, 1);
    chk("c_t5_addr", mem_addr, 32'h4);
    chk("c_t5_gnt", {30'd0, gnt_if, gnt_dm}, 2);
    tick();
    chk("c_t6_if_valid", {31'd0, if_valid}, 0);
    tick();
    chk("c_t7_if_valid", {31'd0, if_valid}, 1);
    chk("c_t7_if_rdata", if_rdata, 32'h00500293);
    if_req = 0;
    tick();
    // starvation
    if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("st_gnt_dm%0d", g), {30'd0, gnt_if, gnt_dm}, 1);
      tick();
      tick();
      chk($sformatf("st_valid%0d", g), {31'd0, dm_valid}, 1);
      tick();
    end
    tick();
    chk("st_gnt_if5", {30'd0, gnt_if, gnt_dm}, 2);
    chk("st_addr5", mem_addr, 32'h4);
    chk("st_cnt_clr", 32'(u1.starve_cnt_q), 0);
    tick();
    tick();
    chk("st_if_valid5", {31'd0, if_valid}, 1);
    tick();
    tick();
    chk("st_gnt_dm6", {30'd0, gnt_if, gnt_dm}, 1);
    if_req = 0; dm_req = 0;
    tick(); tick(); tick(); tick();
    // reset mid-WAIT on the READ_LAT=3 instance
    rst3 = 0; if_req = 1; if_addr = 32'h4;
    tick();
    chk("r3_re", {31'd0, mem_re3}, 1);
    tick();
    tick();
    rst3 = 1;
    tick();
    chk("r3_rst_outs", {28'd0, if_valid3, dm_valid3, gnt_if3, mem_re3}, 0);
    rst3 = 0;
    tick();
    chk("r3_regrant", {31'd0, mem_re3}, 1);
    chk("r3_gnt_if", {31'd0, gnt_if3}, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("r3_novalid%0d", c), {31'd0, if_valid3}, 0);
    end
    if_req = 0;
    tick();
    chk("r3_valid", {31'd0, if_valid3}, 1);
    chk("r3_rdata", if_rdata3, 32'h00500293);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
